// File: rtl/gumnut_pkg.sv
// -----------------------------------------------------------------------------
// gumnut_pkg
//   Types and constants shared by the Gumnut fetch stage, the instruction
//   register and the control unit.
//     IADDR_WIDTH    : instruction address width
//     INST_WIDTH     : instruction word width
//     pc_sel_t       : PC redirection kind selected by the control unit
//     fetch_state_t  : fetch FSM state encoding
// -----------------------------------------------------------------------------
package gumnut_pkg;

    localparam int IADDR_WIDTH = 12;
    localparam int INST_WIDTH  = 18;

    typedef enum logic [1:0] {
        PC_BRANCH = 2'd0,
        PC_JUMP   = 2'd1,
        PC_CALL   = 2'd2,
        PC_RET    = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/gumnut_ret_stack.sv
// -----------------------------------------------------------------------------
// gumnut_ret_stack
//   Return-address LIFO of DEPTH entries, each WIDTH bits wide.
//   Ports:
//     clk, rst      : clock, synchronous active-low reset (clears pointer only)
//     cen           : clock enable; pointer and contents hold when 0
//     push          : write push_data on top (ignored when full)
//     pop           : drop the top entry (ignored when empty)
//     push_data     : value to push
//     top           : current top entry (undefined when empty)
//     full, empty   : occupancy flags
// -----------------------------------------------------------------------------
module gumnut_ret_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra bit so that "full" (sp == DEPTH) is distinguishable from empty.
    logic [PTR_W:0]   sp;
    logic [PTR_W-1:0] top_idx;

    assign full    = (sp == (PTR_W+1)'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = sp[PTR_W-1:0] - PTR_W'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '0;
        end else if (cen) begin
            if (push && !full) begin
                sp <= sp + (PTR_W+1)'(1);
            end else if (pop && !empty) begin
                sp <= sp - (PTR_W+1)'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; only the pointer defines which
    // entries are meaningful, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (cen && push && !full) begin
            mem[sp[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/gumnut_fetch.sv
// -----------------------------------------------------------------------------
// gumnut_fetch
//   Instruction-fetch stage of the Gumnut core. Owns the program counter and
//   the return-address stack, and runs the strobe/ack handshake to
//   instruction memory. Each fetched word is presented on inst_e together
//   with a one-cycle we pulse for the instruction register.
//   Ports:
//     clk, rst             : clock, synchronous active-low reset
//     cen                  : clock enable (reset still acts when low)
//     fetch_req_i          : request next fetch (sampled in IDLE)
//     pc_upd_i, pc_sel_i   : PC redirection strobe and kind (IDLE only)
//     disp_i, addr_i       : signed branch displacement / absolute target
//     imem_addr_o/stb_o    : memory address and request strobe
//     imem_ack_i/dat_i     : memory acknowledge and read data
//     inst_e, we           : fetched word and IR write enable
//     pc_o, busy_o         : current PC, not-IDLE indicator
//     stk_ovf_o, stk_unf_o : sticky stack overflow / underflow
// -----------------------------------------------------------------------------
module gumnut_fetch
    import gumnut_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int IADDR_W     = IADDR_WIDTH,
    parameter int INST_W      = INST_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               fetch_req_i,
    input  logic               pc_upd_i,
    input  pc_sel_t            pc_sel_i,
    input  logic [7:0]         disp_i,
    input  logic [IADDR_W-1:0] addr_i,
    output logic [IADDR_W-1:0] imem_addr_o,
    output logic               imem_stb_o,
    input  logic               imem_ack_i,
    input  logic [INST_W-1:0]  imem_dat_i,
    output logic [INST_W-1:0]  inst_e,
    output logic               we,
    output logic [IADDR_W-1:0] pc_o,
    output logic               busy_o,
    output logic               stk_ovf_o,
    output logic               stk_unf_o
);

    fetch_state_t       state;
    logic [IADDR_W-1:0] pc;
    logic [IADDR_W-1:0] disp_ext;
    logic [IADDR_W-1:0] stk_top;
    logic               stk_full;
    logic               stk_empty;
    logic               upd_ok;
    logic               stk_push;
    logic               stk_pop;

    assign disp_ext    = {{(IADDR_W-8){disp_i[7]}}, disp_i};
    assign imem_addr_o = pc;
    assign pc_o        = pc;

    // Redirection is only honoured in IDLE; the stack sees a push/pop only
    // when it can actually take it, the refused cases raise sticky flags.
    assign upd_ok   = (state == ST_IDLE) && pc_upd_i;
    assign stk_push = upd_ok && (pc_sel_i == PC_CALL) && !stk_full;
    assign stk_pop  = upd_ok && (pc_sel_i == PC_RET)  && !stk_empty;

    gumnut_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (IADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // NOTE: every register here is assigned with <= so all state updates
    // from one edge see the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc         <= '0;
            inst_e     <= '0;
            we         <= 1'b0;
            imem_stb_o <= 1'b0;
            busy_o     <= 1'b0;
            stk_ovf_o  <= 1'b0;
            stk_unf_o  <= 1'b0;
        end else if (cen) begin
            case (state)
                ST_IDLE: begin
                    if (pc_upd_i) begin
                        case (pc_sel_i)
                            PC_BRANCH: pc <= pc + disp_ext;
                            PC_JUMP:   pc <= addr_i;
                            PC_CALL: begin
                                pc <= addr_i;
                                if (stk_full) stk_ovf_o <= 1'b1;
                            end
                            PC_RET: begin
                                if (stk_empty) stk_unf_o <= 1'b1;
                                else           pc        <= stk_top;
                            end
                            default: ;
                        endcase
                    end
                    // A redirect in the same cycle is already reflected in
                    // pc by the time the strobe goes out.
                    if (fetch_req_i) begin
                        state      <= ST_REQ;
                        imem_stb_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        inst_e     <= imem_dat_i;
                        pc         <= pc + IADDR_W'(1);
                        imem_stb_o <= 1'b0;
                        we         <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    we     <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    we         <= 1'b0;
                    imem_stb_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gumnut_fetch.md
Name: gumnut_fetch

Overview:
Instruction-fetch stage of the Gumnut core, directly upstream of the instruction register. It owns the 12-bit program counter and the return-address stack, and runs the request/acknowledge handshake to instruction memory. Each fetched 18-bit word is presented on inst_e with a one-cycle we pulse, so the IR captures it. The control unit drives PC redirection (branch, jump, call, return) from fields already decoded by the IR.

Parameters:
STACK_DEPTH, 8, number of return-address entries (power of two, >= 2)
IADDR_W, 12, instruction address width
INST_W, 18, instruction word width

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low
cen  in  1  clock enable; all state holds when 0 (reset excepted)
fetch_req_i  in  1  control requests the next instruction fetch (level, sampled in IDLE)
pc_upd_i  in  1  one-cycle strobe: apply pc_sel_i
pc_sel_i  in  2  pc_sel_t: PC_BRANCH, PC_JUMP, PC_CALL, PC_RET
disp_i  in  8  signed branch displacement
addr_i  in  IADDR_W  absolute jump/call target
imem_addr_o  out  IADDR_W  instruction memory address
imem_stb_o  out  1  memory request strobe
imem_ack_i  in  1  memory acknowledge; data valid this cycle
imem_dat_i  in  INST_W  memory read data
inst_e  out  INST_W  fetched instruction, to IR
we  out  1  IR write enable, one-cycle pulse
pc_o  out  IADDR_W  current PC
busy_o  out  1  1 in any state other than IDLE
stk_ovf_o  out  1  sticky: push attempted while stack full
stk_unf_o  out  1  sticky: pop attempted while stack empty

Behaviour:
- Reset (rst==0 at a clk edge, regardless of cen): state IDLE; pc, sp, inst_e = 0; we, imem_stb_o, busy_o, stk_ovf_o, stk_unf_o = 0. Stack contents are don't-care.
- cen==0: no state, PC, stack, or output register changes. Outputs hold their values, so a we pulse stretches while cen is low.
- FSM has three states.
  - IDLE: if fetch_req_i==1, go to REQ.
  - REQ: imem_stb_o=1 and imem_addr_o=pc. On imem_ack_i==1: inst_e <= imem_dat_i, pc <= pc+1 (mod 2^IADDR_W), go to DONE. Without ack, remain in REQ indefinitely with the strobe held and the address stable.
  - DONE: we=1 for exactly one enabled cycle, then go to IDLE.
- Minimum latency with same-cycle ack: fetch_req_i sampled at edge N, imem_stb_o high N..N+1, we high N+1..N+2.
- imem_addr_o equals pc in every state; imem_stb_o is 1 only in REQ.
- PC update is accepted only in IDLE. pc_upd_i in any other state is ignored. pc already points past the current instruction.
  - PC_BRANCH: pc <= pc + sign_extend(disp_i), modulo 2^IADDR_W.
  - PC_JUMP: pc <= addr_i.
  - PC_CALL: push pc, then pc <= addr_i. If the stack is full: no push, stk_ovf_o <= 1, and pc <= addr_i still happens.
  - PC_RET: pc <= top entry and sp decrements. If the stack is empty: pc unchanged, stk_unf_o <= 1.
- pc_upd_i and fetch_req_i in the same IDLE cycle: the PC update is applied and the FSM enters REQ in the same edge, so the fetch uses the updated PC.
- Sticky flags clear only on reset.
- Reset mid-fetch (in REQ or DONE): the fetch is abandoned, strobe drops, and no we pulse is issued. A late imem_ack_i is ignored in IDLE.

Decomposition:
- gumnut_pkg holds pc_sel_t, the fetch FSM state enum, and the IADDR_W/INST_W constants shared with the IR and control unit.
- Sub-module gumnut_ret_stack: LIFO of STACK_DEPTH x IADDR_W with push/pop/full/empty/top ports, the same reset rule, and cen gating.

Test Plan:
- Reset, then fetch_req_i=1 with memory ack after 2 cycles and imem_dat_i=0x2A5C3 -> stb held 3 cycles at address 0x000; inst_e=0x2A5C3 with a single we pulse; pc_o=0x001.
- pc=0x001, BRANCH with disp_i=0xFE -> pc_o=0xFFF; next fetch addresses 0xFFF, then pc wraps to 0x000.
- pc=0x010, CALL addr_i=0x3A0, then RET -> pc_o=0x3A0, then 0x010; stk_ovf_o and stk_unf_o remain 0.
- 9 CALLs with STACK_DEPTH=8, then 9 RETs -> stk_ovf_o=1 after the 9th call; returns yield the 8 pushed values in LIFO order; the 9th RET leaves pc unchanged and sets stk_unf_o=1.
- cen=0 for 3 cycles while in DONE -> we stays 1 across those cycles and pc holds; one IR capture occurs when cen returns.
- rst=0 asserted in REQ, followed by a stray ack -> outputs at reset values, no we pulse, state IDLE.
